ifetch_ctrl: RTL and testbench



---
 rtl/mips_pkg.sv | 14 +
 rtl/ifetch_ctrl_ifid_reg.sv | 56 +++++
 rtl/ifetch_ctrl.sv | 128 ++++++++++++
 tb/tb_ifetch_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared widths, NOP encoding and fetch-state encoding for the MIPS pipeline
package mips_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;
    localparam logic [DEF_DATA_W-1:0] MIPS_NOP = 32'h0000_0000;

    typedef enum logic [1:0] {
        FS_REQ,
        FS_WAIT,
        FS_HOLD
    } fetch_state_e;

endpackage

// File: rtl/ifetch_ctrl_ifid_reg.sv
// ifid_reg: IF/ID pipeline register with load, flush and stall-aware consumption
module ifid_reg
    import mips_pkg::*;
#(
    parameter int                ADDR_W    = DEF_ADDR_W,
    parameter int                DATA_W    = DEF_DATA_W,
    parameter logic [DATA_W-1:0] NOP_INSTR = MIPS_NOP
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              load,
    input  logic              stall,
    input  logic [DATA_W-1:0] load_instr,
    input  logic [ADDR_W-1:0] load_pc_plus4,
    output logic              valid,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] pc_plus4
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0] pc4_q, pc4_d;

    // An unstalled decode consumes the entry; a flush wins over a load.
    always_comb begin
        valid_d = valid_q & stall;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        if (flush) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
        end else if (load) begin
            valid_d = 1'b1;
            instr_d = load_instr;
            pc4_d   = load_pc_plus4;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
            pc4_q   <= '0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
        end
    end

    assign valid    = valid_q;
    assign instr    = instr_q;
    assign pc_plus4 = pc4_q;

endmodule

// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl: single-outstanding instruction fetch with skid hold and redirect flush
module ifetch_ctrl
    import mips_pkg::*;
#(
    parameter int                ADDR_W    = DEF_ADDR_W,
    parameter int                DATA_W    = DEF_DATA_W,
    parameter logic [DATA_W-1:0] NOP_INSTR = MIPS_NOP
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc_current,
    input  logic [ADDR_W-1:0] pc_plus4,
    output logic [ADDR_W-1:0] pc_next,
    output logic              pc_enable,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_resp_valid,
    input  logic [DATA_W-1:0] imem_resp_data,
    input  logic              id_stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_target,
    output logic              ifid_valid,
    output logic [DATA_W-1:0] ifid_instr,
    output logic [ADDR_W-1:0] ifid_pc_plus4
);

    fetch_state_e      state_q, state_d;
    logic              drop_q, drop_d;
    logic [DATA_W-1:0] skid_instr_q, skid_instr_d;
    logic [ADDR_W-1:0] skid_pc4_q, skid_pc4_d;
    logic              can_load, req_fire, ld;
    logic [DATA_W-1:0] ld_instr;
    logic [ADDR_W-1:0] ld_pc4;

    assign imem_req_valid = (state_q == FS_REQ);
    assign imem_req_addr  = pc_current;
    assign pc_next        = redirect_valid ? redirect_target : pc_plus4;
    assign can_load       = ~ifid_valid | ~id_stall;
    assign req_fire       = imem_req_valid & imem_req_ready;

    // drop marks an in-flight response that belongs to a squashed or pre-reset fetch.
    always_comb begin
        state_d      = state_q;
        drop_d       = drop_q;
        skid_instr_d = skid_instr_q;
        skid_pc4_d   = skid_pc4_q;
        pc_enable    = 1'b0;
        ld           = 1'b0;
        ld_instr     = imem_resp_data;
        ld_pc4       = pc_plus4;
        if (reset) begin
            state_d      = FS_REQ;
            drop_d       = (state_q == FS_WAIT);
            skid_instr_d = NOP_INSTR;
            skid_pc4_d   = '0;
        end else if (redirect_valid) begin
            pc_enable = 1'b1;
            case (state_q)
                FS_REQ: begin
                    if (req_fire) begin
                        drop_d  = 1'b1;
                        state_d = FS_WAIT;
                    end else if (imem_resp_valid) begin
                        drop_d = 1'b0;
                    end
                end
                FS_WAIT: begin
                    state_d = imem_resp_valid ? FS_REQ : FS_WAIT;
                    drop_d  = ~imem_resp_valid;
                end
                default: state_d = FS_REQ;
            endcase
        end else begin
            case (state_q)
                FS_REQ: begin
                    state_d = req_fire ? FS_WAIT : FS_REQ;
                    drop_d  = drop_q & ~imem_resp_valid;
                end
                FS_WAIT: begin
                    if (imem_resp_valid) begin
                        if (drop_q) begin
                            drop_d  = 1'b0;
                            state_d = FS_REQ;
                        end else begin
                            pc_enable    = 1'b1;
                            ld           = can_load;
                            state_d      = can_load ? FS_REQ : FS_HOLD;
                            skid_instr_d = imem_resp_data;
                            skid_pc4_d   = pc_plus4;
                        end
                    end
                end
                default: begin
                    ld       = can_load;
                    ld_instr = skid_instr_q;
                    ld_pc4   = skid_pc4_q;
                    state_d  = can_load ? FS_REQ : FS_HOLD;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        state_q      <= state_d;
        drop_q       <= drop_d;
        skid_instr_q <= skid_instr_d;
        skid_pc4_q   <= skid_pc4_d;
    end

    ifid_reg #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .NOP_INSTR(NOP_INSTR)
    ) u_ifid (
        .clock        (clock),
        .reset        (reset),
        .flush        (redirect_valid),
        .load         (ld),
        .stall        (id_stall),
        .load_instr   (ld_instr),
        .load_pc_plus4(ld_pc4),
        .valid        (ifid_valid),
        .instr        (ifid_instr),
        .pc_plus4     (ifid_pc_plus4)
    );

endmodule

// File: tb/tb_ifetch_ctrl.sv
// tb_ifetch_ctrl: directed scenario checks of ifetch_ctrl against a bench-side PC register
module tb_ifetch_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] pc_current;
    logic [31:0] pc_plus4;
    logic [31:0] pc_next;
    logic        pc_enable;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        id_stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        ifid_valid;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc_plus4;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (reset) pc_current <= 32'h0;
        else if (pc_enable) pc_current <= pc_next;
    end
    assign pc_plus4 = pc_current + 32'd4;

    ifetch_ctrl dut (
        .clock          (clock),
        .reset          (reset),
        .pc_current     (pc_current),
        .pc_plus4       (pc_plus4),
        .pc_next        (pc_next),
        .pc_enable      (pc_enable),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .id_stall       (id_stall),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .ifid_valid     (ifid_valid),
        .ifid_instr     (ifid_instr),
        .ifid_pc_plus4  (ifid_pc_plus4)
    );

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
        id_stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
        tick; tick;
        redirect_valid = 1'b1; redirect_target = 32'h0000_0040; #1;
        n_checks++; if (pc_enable !== 1'b0) begin n_fail++; $display("FAIL rst_pc_enable: got %b want 0", pc_enable); end
        n_checks++; if (ifid_valid !== 1'b0) begin n_fail++; $display("FAIL rst_ifid_valid: got %b want 0", ifid_valid); end
        n_checks++; if (ifid_instr !== 32'h0) begin n_fail++; $display("FAIL rst_ifid_instr: got %h want 0", ifid_instr); end
        n_checks++; if (ifid_pc_plus4 !== 32'h0) begin n_fail++; $display("FAIL rst_ifid_pc4: got %h want 0", ifid_pc_plus4); end
        n_checks++; if (imem_req_valid !== 1'b1) begin n_fail++; $display("FAIL rst_req_valid: got %b want 1", imem_req_valid); end
        redirect_valid = 1'b0;
        tick;
        reset = 1'b0;
    endtask

    task automatic test_basic_fetch;
        imem_req_ready = 1'b1; #1;
        n_checks++; if (imem_req_addr !== 32'h0) begin n_fail++; $display("FAIL basic_req_addr: got %h want 0", imem_req_addr); end
        n_checks++; if (pc_enable !== 1'b0) begin n_fail++; $display("FAIL basic_no_pc_en_req: got %b want 0", pc_enable); end
        tick;
        imem_req_ready = 1'b0; imem_resp_valid = 1'b1; imem_resp_data = 32'h2002_0005; #1;
        n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL basic_wait_req_valid: got %b want 0", imem_req_valid); end
        n_checks++; if (pc_enable !== 1'b1) begin n_fail++; $display("FAIL basic_pc_en: got %b want 1", pc_enable); end
        n_checks++; if (pc_next !== 32'h4) begin n_fail++; $display("FAIL basic_pc_next: got %h want 4", pc_next); end
        tick;
        imem_resp_valid = 1'b0; #1;
        n_checks++; if (ifid_valid !== 1'b1) begin n_fail++; $display("FAIL basic_ifid_valid: got %b want 1", ifid_valid); end
        n_checks++; if (ifid_instr !== 32'h2002_0005) begin n_fail++; $display("FAIL basic_ifid_instr: got %h want 20020005", ifid_instr); end
        n_checks++; if (ifid_pc_plus4 !== 32'h4) begin n_fail++; $display("FAIL basic_ifid_pc4: got %h want 4", ifid_pc_plus4); end
        n_checks++; if (pc_enable !== 1'b0) begin n_fail++; $display("FAIL basic_pc_en_once: got %b want 0", pc_enable); end
        n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h4) begin n_fail++; $display("FAIL basic_next_req: got %b/%h want 1/4", imem_req_valid, imem_req_addr); end
    endtask

    task automatic test_skid_hold;
        id_stall = 1'b1; imem_req_ready = 1'b1;
        tick;
        imem_req_ready = 1'b0; imem_resp_valid = 1'b1; imem_resp_data = 32'hAAAA_0001; #1;
        n_checks++; if (pc_enable !== 1'b1 || pc_next !== 32'h8) begin n_fail++; $display("FAIL skid_pc_adv: got %b/%h want 1/8", pc_enable, pc_next); end
        tick;
        imem_resp_valid = 1'b0; #1;
        n_checks++; if (ifid_valid !== 1'b1 || ifid_instr !== 32'h2002_0005) begin n_fail++; $display("FAIL skid_ifid_kept: got %b/%h want 1/20020005", ifid_valid, ifid_instr); end
        n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL skid_no_req: got %b want 0", imem_req_valid); end
        n_checks++; if (pc_enable !== 1'b0) begin n_fail++; $display("FAIL skid_hold_pc_en: got %b want 0", pc_enable); end
        tick;
        n_checks++; if (imem_req_valid !== 1'b0 || ifid_instr !== 32'h2002_0005) begin n_fail++; $display("FAIL skid_hold2: got %b/%h want 0/20020005", imem_req_valid, ifid_instr); end
        id_stall = 1'b0;
        tick;
        n_checks++; if (ifid_instr !== 32'hAAAA_0001 || ifid_pc_plus4 !== 32'h8 || ifid_valid !== 1'b1) begin n_fail++; $display("FAIL skid_release: got %b/%h/%h want 1/aaaa0001/8", ifid_valid, ifid_instr, ifid_pc_plus4); end
        n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8) begin n_fail++; $display("FAIL skid_next_req: got %b/%h want 1/8", imem_req_valid, imem_req_addr); end
        tick;
        n_checks++; if (ifid_valid !== 1'b0) begin n_fail++; $display("FAIL consume_clear: got %b want 0", ifid_valid); end
    endtask

    task automatic test_redirect_wait;
        imem_req_ready = 1'b1;
        tick;
        imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h0000_0100; #1;
        n_checks++; if (pc_enable !== 1'b1 || pc_next !== 32'h100) begin n_fail++; $display("FAIL rdw_pc: got %b/%h want 1/100", pc_enable, pc_next); end
        tick;
        redirect_valid = 1'b0; imem_resp_valid = 1'b1; imem_resp_data = 32'hDEAD_BEEF; #1;
        n_checks++; if (ifid_valid !== 1'b0) begin n_fail++; $display("FAIL rdw_ifid_valid: got %b want 0", ifid_valid); end
        n_checks++; if (pc_enable !== 1'b0) begin n_fail++; $display("FAIL rdw_stale_pc_en: got %b want 0", pc_enable); end
        tick;
        imem_resp_valid = 1'b0; #1;
        n_checks++; if (ifid_valid !== 1'b0) begin n_fail++; $display("FAIL rdw_stale_dropped: got %b want 0", ifid_valid); end
        n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin n_fail++; $display("FAIL rdw_new_req: got %b/%h want 1/100", imem_req_valid, imem_req_addr); end
        imem_req_ready = 1'b1;
        tick;
        imem_req_ready = 1'b0; imem_resp_valid = 1'b1; imem_resp_data = 32'h1111_0000; #1;
        n_checks++; if (pc_next !== 32'h104 || pc_enable !== 1'b1) begin n_fail++; $display("FAIL rdw_fetch_pc: got %b/%h want 1/104", pc_enable, pc_next); end
        tick;
        imem_resp_valid = 1'b0; id_stall = 1'b1; #1;
        n_checks++; if (ifid_instr !== 32'h1111_0000 || ifid_pc_plus4 !== 32'h104) begin n_fail++; $display("FAIL rdw_fetch_ifid: got %h/%h want 11110000/104", ifid_instr, ifid_pc_plus4); end
    endtask

    task automatic test_redirect_resp;
        imem_req_ready = 1'b1;
        tick;
        n_checks++; if (ifid_valid !== 1'b1) begin n_fail++; $display("FAIL rdr_ifid_held: got %b want 1", ifid_valid); end
        imem_req_ready = 1'b0; imem_resp_valid = 1'b1; imem_resp_data = 32'h2222_0000;
        redirect_valid = 1'b1; redirect_target = 32'h0000_0200; #1;
        n_checks++; if (pc_enable !== 1'b1 || pc_next !== 32'h200) begin n_fail++; $display("FAIL rdr_pc: got %b/%h want 1/200", pc_enable, pc_next); end
        tick;
        imem_resp_valid = 1'b0; redirect_valid = 1'b0; #1;
        n_checks++; if (ifid_valid !== 1'b0 || ifid_instr !== 32'h0) begin n_fail++; $display("FAIL rdr_flush: got %b/%h want 0/0", ifid_valid, ifid_instr); end
        n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin n_fail++; $display("FAIL rdr_new_req: got %b/%h want 1/200", imem_req_valid, imem_req_addr); end
        id_stall = 1'b0;
    endtask

    task automatic test_retarget;
        imem_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin n_fail++; $display("FAIL rt_hold%0d: got %b/%h want 1/200", i, imem_req_valid, imem_req_addr); end
        end
        redirect_valid = 1'b1; redirect_target = 32'h0000_0300; #1;
        n_checks++; if (pc_enable !== 1'b1) begin n_fail++; $display("FAIL rt_pc_en: got %b want 1", pc_enable); end
        tick;
        redirect_valid = 1'b0; #1;
        n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h300) begin n_fail++; $display("FAIL rt_addr: got %b/%h want 1/300", imem_req_valid, imem_req_addr); end
        imem_req_ready = 1'b1;
        tick;
        imem_req_ready = 1'b0; imem_resp_valid = 1'b1; imem_resp_data = 32'h3333_0000; #1;
        n_checks++; if (pc_enable !== 1'b1 || pc_next !== 32'h304) begin n_fail++; $display("FAIL rt_no_drop: got %b/%h want 1/304", pc_enable, pc_next); end
        tick;
        imem_resp_valid = 1'b0; #1;
        n_checks++; if (ifid_valid !== 1'b1 || ifid_instr !== 32'h3333_0000) begin n_fail++; $display("FAIL rt_ifid: got %b/%h want 1/33330000", ifid_valid, ifid_instr); end
    endtask

    task automatic test_reset_in_wait;
        imem_req_ready = 1'b1;
        tick;
        imem_req_ready = 1'b0; reset = 1'b1;
        tick;
        reset = 1'b0; imem_req_ready = 1'b1;
        tick;
        imem_req_ready = 1'b0;
        tick;
        imem_resp_valid = 1'b1; imem_resp_data = 32'hBAD0_BAD0; #1;
        n_checks++; if (pc_enable !== 1'b0) begin n_fail++; $display("FAIL rw_stale_pc_en: got %b want 0", pc_enable); end
        tick;
        imem_resp_valid = 1'b0; #1;
        n_checks++; if (ifid_valid !== 1'b0) begin n_fail++; $display("FAIL rw_stale_ignored: got %b want 0", ifid_valid); end
        n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin n_fail++; $display("FAIL rw_fresh_req: got %b/%h want 1/0", imem_req_valid, imem_req_addr); end
        imem_req_ready = 1'b1;
        tick;
        imem_req_ready = 1'b0; imem_resp_valid = 1'b1; imem_resp_data = 32'h4444_0000;
        tick;
        imem_resp_valid = 1'b0; #1;
        n_checks++; if (ifid_valid !== 1'b1 || ifid_instr !== 32'h4444_0000 || ifid_pc_plus4 !== 32'h4) begin n_fail++; $display("FAIL rw_fresh_ifid: got %b/%h/%h want 1/44440000/4", ifid_valid, ifid_instr, ifid_pc_plus4); end
    endtask

    initial begin
        test_reset;
        test_basic_fetch;
        test_skid_hold;
        test_redirect_wait;
        test_redirect_resp;
        test_retarget;
        test_reset_in_wait;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
